// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t   : control FSM states (IDLE, RUN, DONE)
//   cnt_width : bit-counter width for a given operand width
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter only has to reach width-1, so clog2(width) bits suffice.
  // The floor of 1 keeps the vector legal for degenerate widths.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_sub_cell.sv
// One-bit full subtractor: computes a - b - bin.
//   a, b  : operand bits
//   bin   : borrow in
//   diff  : difference bit
//   bout  : borrow out
module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  // A borrow is generated when a=0,b=1, and propagated when a==b.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, one bit per clock,
// LSB first, through a single full_sub_cell and a borrow flop.
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset
//   start : request, accepted in IDLE or DONE
//   a, b  : minuend / subtrahend, captured at the accepting edge
//   bin   : borrow-in, captured at the accepting edge
//   busy  : high while bits are being processed
//   done  : one-cycle pulse, diff/bout valid
//   diff  : registered difference, held until the next completion
//   bout  : registered final borrow-out, held with diff
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_next;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             load, step, last;
  logic             cell_d, cell_bout;

  full_sub_cell u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (br),
    .diff (cell_d),
    .bout (cell_bout)
  );

  // Result fills from the MSB side so that after WIDTH shifts bit 0 sits at LSB.
  assign res_next = {cell_d, res_sr[WIDTH-1:1]};
  assign last     = (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: every datapath register is reset, including the internal shift
  // registers, so an aborted operation leaves no residue behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
    end else if (load) begin
      a_sr <= a;
      b_sr <= b;
      br   <= bin;
      cnt  <= '0;
    end else if (step) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      br     <= cell_bout;
      res_sr <= res_next;
      if (last) begin
        diff <= res_next;
        bout <= cell_bout;
      end else begin
        // Holding at WIDTH-1 keeps the counter from wrapping when WIDTH is 2^CW.
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit instance
  logic       rst8, start8, bin8, busy8, done8, bout8;
  logic [7:0] a8, b8, diff8;

  // 3-bit instance for the exhaustive sweep
  logic       rst3, start3, bin3, busy3, done3, bout3;
  logic [2:0] a3, b3, diff3;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  serial_subtractor #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst3), .start(start3), .a(a3), .b(b3), .bin(bin3),
    .busy(busy3), .done(done3), .diff(diff3), .bout(bout3)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       bout;
  } vec_t;

  // From the current negedge, advance until done is seen, counting busy cycles.
  task automatic wait_done8(output int busy_cycles, output bit seen);
    busy_cycles = 0;
    seen        = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (done8) begin
        seen = 1'b1;
        break;
      end
      if (busy8) busy_cycles++;
      @(negedge clk);
    end
  endtask

  task automatic wait_done3(output int busy_cycles, output bit seen);
    busy_cycles = 0;
    seen        = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (done3) begin
        seen = 1'b1;
        break;
      end
      if (busy3) busy_cycles++;
      @(negedge clk);
    end
  endtask

  // Single operation on the 8-bit instance, with operands scrambled after acceptance.
  task automatic run_vec8(input vec_t v, input string tag);
    int bc;
    bit seen;
    @(negedge clk);
    a8 = v.a; b8 = v.b; bin8 = v.bin; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = ~v.a; b8 = ~v.b; bin8 = ~v.bin;
    wait_done8(bc, seen);
    check({tag, " done seen"}, 64'(seen), 64'd1);
    check({tag, " busy cycles"}, 64'(bc), 64'd8);
    check({tag, " diff"}, 64'(diff8), 64'(v.diff));
    check({tag, " bout"}, 64'(bout8), 64'(v.bout));
    @(negedge clk);
    check({tag, " done single pulse"}, 64'(done8), 64'd0);
  endtask

  vec_t vecs[8];

  initial begin
    int  bc, bc2;
    bit  seen;
    int  done_cnt;
    logic [3:0] exp4;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h80, 8'h00, 1'b1, 8'h7F, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    vecs[6] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
    vecs[7] = '{8'h01, 8'hFF, 1'b1, 8'h01, 1'b1};

    rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    rst3 = 1'b1; start3 = 1'b0; a3 = '0; b3 = '0; bin3 = 1'b0;
    repeat (2) @(negedge clk);
    check("reset busy", 64'(busy8), 64'd0);
    check("reset done", 64'(done8), 64'd0);
    check("reset diff", 64'(diff8), 64'd0);
    check("reset bout", 64'(bout8), 64'd0);
    rst8 = 1'b0;
    rst3 = 1'b0;

    foreach (vecs[i]) run_vec8(vecs[i], $sformatf("vec%0d", i));

    // start during RUN is ignored; start held through DONE launches the next op
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    a8 = 8'h00; b8 = 8'hFF; bin8 = 1'b0;   // start stays high while in RUN
    wait_done8(bc, seen);
    check("ignore done seen", 64'(seen), 64'd1);
    check("ignore busy cycles", 64'(bc), 64'd8);
    check("ignore diff", 64'(diff8), 64'h0F);
    check("ignore bout", 64'(bout8), 64'd0);
    @(negedge clk);
    start8 = 1'b0;
    check("b2b done dropped", 64'(done8), 64'd0);
    check("b2b busy rises", 64'(busy8), 64'd1);
    wait_done8(bc2, seen);
    check("b2b done seen", 64'(seen), 64'd1);
    check("b2b busy cycles", 64'(bc2), 64'd8);
    check("b2b diff", 64'(diff8), 64'h01);
    check("b2b bout", 64'(bout8), 64'd1);

    // asynchronous reset 4 cycles into RUN
    @(negedge clk);
    a8 = 8'hC3; b8 = 8'h11; bin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    check("pre-abort busy", 64'(busy8), 64'd1);
    #2 rst8 = 1'b1;
    #1;
    check("abort busy", 64'(busy8), 64'd0);
    check("abort done", 64'(done8), 64'd0);
    check("abort diff", 64'(diff8), 64'd0);
    check("abort bout", 64'(bout8), 64'd0);
    @(negedge clk);
    rst8 = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done8 || busy8) done_cnt++;
    end
    check("no activity after abort", 64'(done_cnt), 64'd0);

    // exhaustive WIDTH=3 sweep, start held high for back-to-back operation
    @(negedge clk);
    {a3, b3, bin3} = 7'd0;
    start3 = 1'b1;
    for (int i = 0; i < 128; i++) begin
      logic [6:0] cur;
      cur = 7'(i);
      @(posedge clk);
      @(negedge clk);
      if (i == 127) start3 = 1'b0;
      else          {a3, b3, bin3} = 7'(i + 1);
      wait_done3(bc, seen);
      exp4 = 4'({1'b0, cur[6:4]} - {1'b0, cur[3:1]} - {3'b000, cur[0]});
      check($sformatf("w3 seen %0d", i), 64'(seen), 64'd1);
      check($sformatf("w3 busy %0d", i), 64'(bc), 64'd3);
      check($sformatf("w3 result %0d", i), 64'({bout3, diff3}), 64'(exp4));
      if (!seen) break;
    end
    @(negedge clk);
    check("w3 idle at end", 64'({busy3, done3}), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
